n64adv_vout_stage: RTL and testbench

//  Parametrised final video output stage. Sits after colour conversion (vconv) and drives the DAC pins.

---
 rtl/n64adv_vout_stage.sv | 157 +++++++++++++++
 tb/tb_n64adv_vout_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n64adv_vout_stage.sv
// Final video output stage: HOLD blanking, colour-vs-sync delay line,
// CSYNC routing and VGA-sync / filter AddOn pin multiplexing.
module n64adv_vout_stage #(
   parameter int COLOR_W  = 8,
   parameter int MAX_DLY  = 4,
   parameter int HOLD_CYC = 255,
   localparam int DLY_W   = $clog2(MAX_DLY + 1)
) (
   input  logic                   VCLK,
   input  logic                   nVRST,
   input  logic                   cfg_testpat,
   input  logic [1:0]             cfg_linemult,
   input  logic [DLY_W-1:0]       cfg_dly,
   input  logic                   cfg_nEN_RGsB,
   input  logic                   cfg_nEN_YPbPr,
   input  logic [2:0]             cfg_filter,
   input  logic                   UseVGA_HVSync,
   input  logic [3:0]             sync_i,
   input  logic [3*COLOR_W-1:0]   vdata_i,
   output logic [3*COLOR_W-1:0]   vdata_o,
   output logic [1:0]             nCSYNC,
   output logic                   nVSYNC_or_F2,
   output logic                   nHSYNC_or_F1,
   output logic [1:0]             filter_o,
   output logic                   hold_active
);

   localparam int PIX_W = 3 * COLOR_W;
   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(HOLD_CYC - 1);
   localparam logic [DLY_W-1:0] SEL_MAX = DLY_W'(MAX_DLY);

   typedef enum logic {ST_HOLD, ST_RUN} state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             tp_sh;
   logic [1:0]       lm_sh;
   logic             mode_chg;
   logic             hold_nxt;
   logic [DLY_W-1:0] sel;
   logic [PIX_W-1:0] tap;
   logic [PIX_W-1:0] dl_q [MAX_DLY];
   logic [1:0]       filt_res;
   logic             csync_en;
   logic             unused_nblank;

   assign unused_nblank = sync_i[2];

   assign mode_chg = (cfg_testpat != tp_sh) || (cfg_linemult != lm_sh);

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         tp_sh <= cfg_testpat;
         lm_sh <= cfg_linemult;
      end else begin
         tp_sh <= cfg_testpat;
         lm_sh <= cfg_linemult;
      end
   end

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         state_q <= ST_HOLD;
         cnt_q   <= CNT_RLD;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // a mode change always restarts the full blanking interval
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         ST_HOLD: begin
            if (mode_chg)
               cnt_nxt = CNT_RLD;
            else if (cnt_q == '0)
               state_nxt = ST_RUN;
            else
               cnt_nxt = cnt_q - CNT_W'(1);
         end
         ST_RUN: begin
            if (mode_chg) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CNT_RLD;
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CNT_RLD;
         end
      endcase
   end

   assign hold_nxt = (state_nxt == ST_HOLD);

   assign sel = (cfg_dly > SEL_MAX) ? SEL_MAX : cfg_dly;

   always_comb begin
      tap = vdata_i;
      for (int k = 1; k <= MAX_DLY; k++)
         if (sel == DLY_W'(k))
            tap = dl_q[k-1];
   end

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         for (int k = 0; k < MAX_DLY; k++)
            dl_q[k] <= '0;
      end else begin
         dl_q[0] <= hold_nxt ? '0 : vdata_i;
         for (int k = 1; k < MAX_DLY; k++)
            dl_q[k] <= dl_q[k-1];
      end
   end

   assign filt_res = (cfg_filter == 3'd0) ? cfg_linemult
                                          : (cfg_filter[1:0] - 2'd1);

   assign csync_en = !cfg_nEN_RGsB || !cfg_nEN_YPbPr;

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         vdata_o      <= '0;
         nCSYNC       <= '0;
         nVSYNC_or_F2 <= 1'b0;
         nHSYNC_or_F1 <= 1'b0;
         filter_o     <= '0;
         hold_active  <= 1'b1;
      end else begin
         hold_active <= hold_nxt;
         filter_o    <= filt_res;
         if (hold_nxt) begin
            vdata_o      <= '0;
            nCSYNC       <= '0;
            nVSYNC_or_F2 <= 1'b0;
            nHSYNC_or_F1 <= 1'b0;
         end else begin
            vdata_o <= tap;
            nCSYNC  <= {sync_i[0], sync_i[0] & csync_en};
            if (UseVGA_HVSync) begin
               nVSYNC_or_F2 <= sync_i[3];
               nHSYNC_or_F1 <= sync_i[1];
            end else begin
               nVSYNC_or_F2 <= filter_o[0];
               nHSYNC_or_F1 <= filter_o[1];
            end
         end
      end
   end

endmodule

// File: tb/tb_n64adv_vout_stage.sv
// Bench for n64adv_vout_stage: cycle model with remaining-hold counter
// and capture history, plus directed literal checks.
module tb_n64adv_vout_stage;

   localparam int COLOR_W  = 8;
   localparam int MAX_DLY  = 4;
   localparam int HOLD_CYC = 255;
   localparam int DLY_W    = 3;
   localparam int PIX_W    = 3 * COLOR_W;

   logic             VCLK = 1'b0;
   logic             nVRST;
   logic             cfg_testpat;
   logic [1:0]       cfg_linemult;
   logic [DLY_W-1:0] cfg_dly;
   logic             cfg_nEN_RGsB;
   logic             cfg_nEN_YPbPr;
   logic [2:0]       cfg_filter;
   logic             UseVGA_HVSync;
   logic [3:0]       sync_i;
   logic [PIX_W-1:0] vdata_i;
   logic [PIX_W-1:0] vdata_o;
   logic [1:0]       nCSYNC;
   logic             nVSYNC_or_F2;
   logic             nHSYNC_or_F1;
   logic [1:0]       filter_o;
   logic             hold_active;

   n64adv_vout_stage #(
      .COLOR_W(COLOR_W), .MAX_DLY(MAX_DLY), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .VCLK(VCLK), .nVRST(nVRST),
      .cfg_testpat(cfg_testpat), .cfg_linemult(cfg_linemult),
      .cfg_dly(cfg_dly), .cfg_nEN_RGsB(cfg_nEN_RGsB),
      .cfg_nEN_YPbPr(cfg_nEN_YPbPr), .cfg_filter(cfg_filter),
      .UseVGA_HVSync(UseVGA_HVSync), .sync_i(sync_i),
      .vdata_i(vdata_i), .vdata_o(vdata_o), .nCSYNC(nCSYNC),
      .nVSYNC_or_F2(nVSYNC_or_F2), .nHSYNC_or_F1(nHSYNC_or_F1),
      .filter_o(filter_o), .hold_active(hold_active)
   );

   always #5 VCLK = ~VCLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: rem = hold cycles left, hist[k] = colour captured k edges ago
   int               rem;
   int               k_m;
   logic             tp_prev;
   logic [1:0]       lm_prev;
   logic [PIX_W-1:0] hist [0:MAX_DLY];
   logic [1:0]       filt_prev;
   logic [1:0]       filt_e;
   logic [PIX_W-1:0] v_e;
   logic [1:0]       cs_e;
   logic             vs_e, hs_e, h_e;

   always @(posedge VCLK) begin
      if (!nVRST) begin
         rem = HOLD_CYC;
         tp_prev = cfg_testpat;
         lm_prev = cfg_linemult;
         for (int i = 0; i <= MAX_DLY; i++) hist[i] = '0;
         filt_prev = 2'd0;
         filt_e = 2'd0;
         v_e = '0;
         cs_e = 2'd0;
         vs_e = 1'b0;
         hs_e = 1'b0;
         h_e = 1'b1;
      end else begin
         if (cfg_testpat != tp_prev || cfg_linemult != lm_prev)
            rem = HOLD_CYC;
         else if (rem > 0)
            rem = rem - 1;
         tp_prev = cfg_testpat;
         lm_prev = cfg_linemult;
         h_e = (rem > 0);
         for (int i = MAX_DLY; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = h_e ? '0 : vdata_i;
         k_m = (int'(cfg_dly) > MAX_DLY) ? MAX_DLY : int'(cfg_dly);
         v_e = h_e ? '0 : hist[k_m];
         cs_e = h_e ? 2'd0 :
                {sync_i[0], sync_i[0] & (!cfg_nEN_RGsB || !cfg_nEN_YPbPr)};
         if (h_e) begin
            vs_e = 1'b0;
            hs_e = 1'b0;
         end else if (UseVGA_HVSync) begin
            vs_e = sync_i[3];
            hs_e = sync_i[1];
         end else begin
            vs_e = filt_prev[0];
            hs_e = filt_prev[1];
         end
         filt_e = (cfg_filter == 3'd0) ? cfg_linemult
                                       : 2'((int'(cfg_filter) + 3) % 4);
         filt_prev = filt_e;
      end
      #1;
      chk("m_hold", hold_active, h_e);
      chk("m_vdata", vdata_o, v_e);
      chk("m_csync", nCSYNC, cs_e);
      chk("m_vs_f2", nVSYNC_or_F2, vs_e);
      chk("m_hs_f1", nHSYNC_or_F1, hs_e);
      chk("m_filter", filter_o, filt_e);
   end

   task automatic step();
      vdata_i = vdata_i + 1'b1;
      sync_i  = vdata_i[3:0];
      @(negedge VCLK);
   endtask

   task automatic count_hold(input string name, input int exp);
      int n;
      bit done;
      n = 0;
      done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge VCLK);
         if (hold_active) n++;
         else done = 1;
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
      else chk(name, n, exp);
   endtask

   int dly_t [3]  = '{0, 2, 7};
   int lag_t [3]  = '{0, 2, 4};
   int flt_t [5]  = '{0, 1, 2, 3, 4};
   int fexp_t [5] = '{2, 0, 1, 2, 3};

   initial begin
      nVRST = 1'b1;
      cfg_testpat = 1'b0;
      cfg_linemult = 2'd2;
      cfg_dly = '0;
      cfg_nEN_RGsB = 1'b1;
      cfg_nEN_YPbPr = 1'b1;
      cfg_filter = 3'd0;
      UseVGA_HVSync = 1'b1;
      sync_i = 4'd0;
      vdata_i = 24'hFFFFFF;
      #1 nVRST = 1'b0;
      #2;
      chk("rst_vdata", vdata_o, 0);
      chk("rst_hold", hold_active, 1);
      chk("rst_csync", nCSYNC, 0);
      @(negedge VCLK);
      @(negedge VCLK);
      nVRST = 1'b1;

      repeat (HOLD_CYC - 1) @(negedge VCLK);
      chk("t1_hold_last", hold_active, 1);
      chk("t1_vdata_last", vdata_o, 0);
      @(negedge VCLK);
      chk("t1_hold_end", hold_active, 0);
      chk("t1_first_data", vdata_o, 24'hFFFFFF);

      vdata_i = 24'h000100;
      for (int i = 0; i < 3; i++) begin
         cfg_dly = DLY_W'(dly_t[i]);
         repeat (8) step();
         chk("t2_lag", 32'(24'(vdata_i - vdata_o)), lag_t[i]);
      end

      cfg_dly = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_csync_off", nCSYNC, {sync_i[0], 1'b0});
      end
      cfg_nEN_YPbPr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_csync_ypbpr", nCSYNC, {2{sync_i[0]}});
      end
      cfg_nEN_YPbPr = 1'b1;
      cfg_nEN_RGsB = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t5_csync_rgsb", nCSYNC, {2{sync_i[0]}});
      end

      sync_i = 4'b1000;
      UseVGA_HVSync = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cfg_filter = 3'(flt_t[i]);
         @(negedge VCLK);
         @(negedge VCLK);
         chk("t4_filter", filter_o, fexp_t[i]);
         chk("t4_pins", {nHSYNC_or_F1, nVSYNC_or_F2}, fexp_t[i]);
      end
      UseVGA_HVSync = 1'b1;
      @(negedge VCLK);
      chk("t4_vga_a", {nVSYNC_or_F2, nHSYNC_or_F1}, 2'b10);
      sync_i = 4'b0010;
      @(negedge VCLK);
      chk("t4_vga_b", {nVSYNC_or_F2, nHSYNC_or_F1}, 2'b01);

      vdata_i = 24'h123456;
      sync_i = 4'b1011;
      @(negedge VCLK);
      cfg_testpat = 1'b1;
      @(negedge VCLK);
      chk("t3_hold_rise", hold_active, 1);
      chk("t3_vdata0", vdata_o, 0);
      chk("t3_csync0", nCSYNC, 0);
      chk("t3_pins0", {nVSYNC_or_F2, nHSYNC_or_F1}, 0);
      repeat (99) @(negedge VCLK);
      cfg_linemult = 2'd1;
      count_hold("t3_hold_extend", HOLD_CYC);
      chk("t3_resume", vdata_o, 24'h123456);

      repeat (6) step();
      #2 nVRST = 1'b0;
      #1;
      chk("t6_async_vdata", vdata_o, 0);
      chk("t6_async_csync", nCSYNC, 0);
      chk("t6_async_pins", {nVSYNC_or_F2, nHSYNC_or_F1}, 0);
      chk("t6_async_filter", filter_o, 0);
      chk("t6_async_hold", hold_active, 1);
      @(negedge VCLK);
      @(negedge VCLK);
      nVRST = 1'b1;
      count_hold("t6_replay", HOLD_CYC - 1);
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
